// File: rtl/s_seq_monitor_if.sv
// Bundle between the alternating-key sequence FSM and its downstream monitor.
// No valid/ready here: every rising clk edge with clr=0 is a sample of s and k.
interface s_seq_monitor_if;
    logic [1:0] s;
    logic       k;
    logic       err_clr;
    logic [7:0] cyc_bcd;
    logic       cyc_wrap;
    logic       err;
    logic [3:0] err_cnt;
    logic       stall;
    logic       primed;   // debug view of the monitor's only control state

    modport master (
        output s, k, err_clr,
        input  cyc_bcd, cyc_wrap, err, err_cnt, stall, primed
    );

    modport slave (
        input  s, k, err_clr,
        output cyc_bcd, cyc_wrap, err, err_cnt, stall, primed
    );
endinterface

// File: rtl/s_seq_monitor.sv
// Checker for the 2-bit alternating-key sequence FSM: predicts each next state,
// counts completed 00..11 cycles in BCD, flags illegal steps and detects stalls.
module s_seq_monitor #(
    parameter int unsigned STALL_MAX = 16
) (
    input logic           clk,
    input logic           clr,
    s_seq_monitor_if.slave bus
);
    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_01 = 2'b01;
    localparam logic [1:0] ST_10 = 2'b10;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [7:0] STALL_LIM = 8'(STALL_MAX);

    logic [1:0] prev_s;
    logic       prev_k;
    logic       primed;
    logic [7:0] run_cnt;
    logic [7:0] cyc_bcd;
    logic       cyc_wrap;
    logic       err;
    logic [3:0] err_cnt;
    logic       stall;

    logic [1:0] pred_s;
    logic       mismatch;
    logic       count_hit;
    logic [7:0] cyc_nxt;
    logic [7:0] run_nxt;
    logic [3:0] err_cnt_inc;

    // The key that was sampled alongside prev_s is the one that moved the FSM.
    always_comb begin
        pred_s = prev_s;
        case ({prev_k, prev_s})
            {1'b1, ST_01}: pred_s = ST_10;
            {1'b1, ST_11}: pred_s = ST_00;
            {1'b0, ST_00}: pred_s = ST_01;
            {1'b0, ST_10}: pred_s = ST_11;
            default:       pred_s = prev_s;
        endcase
    end

    assign mismatch  = primed && (bus.s != pred_s);
    assign count_hit = primed && (prev_s == ST_11) && (bus.s == ST_00) && !mismatch;
    assign err_cnt_inc = (err_cnt == 4'hf) ? 4'hf : err_cnt + 4'd1;

    always_comb begin
        cyc_nxt = cyc_bcd;
        if (cyc_bcd[3:0] == 4'd9) begin
            cyc_nxt[3:0] = 4'd0;
            cyc_nxt[7:4] = (cyc_bcd[7:4] == 4'd9) ? 4'd0 : cyc_bcd[7:4] + 4'd1;
        end else begin
            cyc_nxt[3:0] = cyc_bcd[3:0] + 4'd1;
        end
    end

    always_comb begin
        run_nxt = run_cnt;
        if (bus.s != prev_s) begin
            run_nxt = 8'd1;
        end else if (run_cnt < STALL_LIM) begin
            run_nxt = run_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prev_s   <= ST_00;
            prev_k   <= 1'b0;
            primed   <= 1'b0;
            run_cnt  <= 8'd0;
            cyc_bcd  <= 8'd0;
            cyc_wrap <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= 4'd0;
            stall    <= 1'b0;
        end else begin
            prev_s   <= bus.s;
            prev_k   <= bus.k;
            primed   <= 1'b1;
            cyc_wrap <= count_hit && (cyc_bcd == 8'h99);

            // A mismatch on the same edge as err_clr restarts the tally at one.
            if (mismatch) begin
                err     <= 1'b1;
                err_cnt <= bus.err_clr ? 4'd1 : err_cnt_inc;
            end else if (bus.err_clr) begin
                err     <= 1'b0;
                err_cnt <= 4'd0;
            end

            if (count_hit) begin
                cyc_bcd <= cyc_nxt;
            end

            if (primed) begin
                run_cnt <= run_nxt;
                stall   <= (run_nxt >= STALL_LIM);
            end
        end
    end

    assign bus.cyc_bcd  = cyc_bcd;
    assign bus.cyc_wrap = cyc_wrap;
    assign bus.err      = err;
    assign bus.err_cnt  = err_cnt;
    assign bus.stall    = stall;
    assign bus.primed   = primed;
endmodule

// File: tb/tb_s_seq_monitor.sv
// Randomised and directed bench for s_seq_monitor against a rule-level model.
module tb_s_seq_monitor;
    localparam int STALL_MAX = 16;

    logic clk;
    logic clr;
    int   n_chk;
    int   n_pass;
    logic chk_en;

    s_seq_monitor_if bus ();

    s_seq_monitor #(.STALL_MAX(STALL_MAX)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next FSM state: the key advances the state only when it matches s[0].
    function automatic logic [1:0] pred(input logic [1:0] ps, input logic pk);
        return (ps[0] == pk) ? ps + 2'd1 : ps;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // behavioural model
    logic [1:0] m_ps;
    logic       m_pk;
    logic       m_primed;
    int         m_cyc;
    int         m_run;
    logic       m_wrap;
    logic       m_err;
    int         m_ecnt;
    logic       m_mism;
    logic       m_hit;

    assign m_mism = m_primed && (bus.s != pred(m_ps, m_pk));
    assign m_hit  = m_primed && (m_ps == 2'b11) && (bus.s == 2'b00) && !m_mism;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_ps <= 2'b00; m_pk <= 1'b0; m_primed <= 1'b0;
            m_cyc <= 0; m_run <= 0; m_wrap <= 1'b0; m_err <= 1'b0; m_ecnt <= 0;
        end else begin
            m_ps <= bus.s;
            m_pk <= bus.k;
            m_primed <= 1'b1;
            m_wrap <= m_hit && (m_cyc == 99);
            if (m_hit) m_cyc <= (m_cyc + 1) % 100;
            if (m_mism) begin
                m_err  <= 1'b1;
                m_ecnt <= bus.err_clr ? 1 : ((m_ecnt >= 15) ? 15 : m_ecnt + 1);
            end else if (bus.err_clr) begin
                m_err <= 1'b0;
                m_ecnt <= 0;
            end
            if (m_primed) begin
                if (bus.s != m_ps) m_run <= 1;
                else if (m_run < STALL_MAX) m_run <= m_run + 1;
            end
        end
    end

    // scoreboard: every negedge the registered outputs must match the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_bcd",  {24'd0, bus.cyc_bcd}, 32'((m_cyc / 10) * 16 + (m_cyc % 10)));
            check("cyc_wrap", {31'd0, bus.cyc_wrap}, {31'd0, m_wrap});
            check("err",      {31'd0, bus.err},      {31'd0, m_err});
            check("err_cnt",  {28'd0, bus.err_cnt},  32'(m_ecnt));
            check("stall",    {31'd0, bus.stall},    {31'd0, (m_run >= STALL_MAX)});
            check("primed",   {31'd0, bus.primed},   {31'd0, m_primed});
        end
    end

    // driver tasks
    logic [1:0] last_s;
    logic       last_k;

    task automatic drive(input logic [1:0] ns, input logic nk, input logic nclr);
        bus.s = ns;
        bus.k = nk;
        bus.err_clr = nclr;
        last_s = ns;
        last_k = nk;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_tail();
        drive(2'b01, 1'b1, 1'b0);
        drive(2'b10, 1'b0, 1'b0);
        drive(2'b11, 1'b1, 1'b0);
        drive(2'b00, 1'b0, 1'b0);
    endtask

    task automatic reset_dut();
        clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        logic [1:0] nxt;
        logic       chg;
        n_chk = 0;
        n_pass = 0;
        chk_en = 1'b0;
        clr = 1'b1;
        bus.s = 2'b00;
        bus.k = 1'b0;
        bus.err_clr = 1'b0;
        last_s = 2'b00;
        last_k = 1'b0;
        #1;
        chk_en = 1'b1;
        reset_dut();
        check("rst_cyc_bcd", {24'd0, bus.cyc_bcd}, 32'h0);
        check("rst_err_cnt", {28'd0, bus.err_cnt}, 32'h0);

        // first cycle and 100-cycle BCD run
        drive(2'b00, 1'b0, 1'b0);
        cycle_tail();
        check("cyc1_bcd",   {24'd0, bus.cyc_bcd}, 32'h01);
        check("cyc1_err",   {31'd0, bus.err},      32'h0);
        check("cyc1_stall", {31'd0, bus.stall},    32'h0);
        check("cyc1_wrap",  {31'd0, bus.cyc_wrap}, 32'h0);
        for (int n = 2; n <= 100; n++) begin
            cycle_tail();
            if (n == 9)  check("cyc9_bcd",   {24'd0, bus.cyc_bcd}, 32'h09);
            if (n == 10) check("cyc10_bcd",  {24'd0, bus.cyc_bcd}, 32'h10);
            if (n == 99) check("cyc99_bcd",  {24'd0, bus.cyc_bcd}, 32'h99);
            if (n == 99) check("cyc99_wrap", {31'd0, bus.cyc_wrap}, 32'h0);
            if (n == 100) check("cyc100_bcd",  {24'd0, bus.cyc_bcd}, 32'h00);
            if (n == 100) check("cyc100_wrap", {31'd0, bus.cyc_wrap}, 32'h1);
        end

        // skip 01: 00 -> 10 with prev_k=0
        drive(2'b10, 1'b0, 1'b0);
        check("skip_wrap", {31'd0, bus.cyc_wrap}, 32'h0);
        check("skip_err",  {31'd0, bus.err},      32'h1);
        check("skip_cnt",  {28'd0, bus.err_cnt},  32'h1);
        check("skip_cyc",  {24'd0, bus.cyc_bcd},  32'h00);
        for (int i = 0; i < 16; i++) begin
            drive(pred(last_s, last_k) ^ 2'b10, 1'($urandom_range(0, 1)), 1'b0);
        end
        check("sat_cnt", {28'd0, bus.err_cnt}, 32'hf);
        check("sat_cyc", {24'd0, bus.cyc_bcd}, 32'h00);

        // err_clr alone, then colliding with a mismatch
        drive(pred(last_s, last_k), 1'($urandom_range(0, 1)), 1'b1);
        check("clr_err", {31'd0, bus.err},     32'h0);
        check("clr_cnt", {28'd0, bus.err_cnt}, 32'h0);
        drive(pred(last_s, last_k) ^ 2'b10, 1'($urandom_range(0, 1)), 1'b1);
        check("clrmis_err", {31'd0, bus.err},     32'h1);
        check("clrmis_cnt", {28'd0, bus.err_cnt}, 32'h1);
        drive(pred(last_s, last_k), 1'($urandom_range(0, 1)), 1'b1);

        // walk legally onto 00 (a real change), then hold with k=1
        for (int i = 0; i < 8; i++) begin
            nxt = pred(last_s, last_k);
            chg = (nxt != last_s);
            drive(nxt, (nxt == 2'b00 && chg) ? 1'b1 : nxt[0], 1'b0);
            if (nxt == 2'b00 && chg) break;
        end
        for (int j = 1; j <= 20; j++) begin
            drive(2'b00, 1'b1, 1'b0);
            if (j == 14) check("stall_pre",  {31'd0, bus.stall}, 32'h0);
            if (j == 15) check("stall_rise", {31'd0, bus.stall}, 32'h1);
        end
        check("stall_err", {31'd0, bus.err}, 32'h0);
        drive(2'b00, 1'b0, 1'b0);
        check("stall_hold", {31'd0, bus.stall}, 32'h1);
        drive(2'b01, 1'b1, 1'b0);
        check("stall_fall", {31'd0, bus.stall}, 32'h0);
        check("stall_err2", {31'd0, bus.err},   32'h0);

        // async clear mid-sequence at s=10 with count 05
        reset_dut();
        drive(2'b00, 1'b0, 1'b0);
        repeat (5) cycle_tail();
        check("pre_rst_cyc", {24'd0, bus.cyc_bcd}, 32'h05);
        drive(2'b01, 1'b1, 1'b0);
        drive(2'b10, 1'b0, 1'b0);
        #2;
        clr = 1'b1;
        #1;
        check("arst_cyc",   {24'd0, bus.cyc_bcd},  32'h0);
        check("arst_wrap",  {31'd0, bus.cyc_wrap}, 32'h0);
        check("arst_err",   {31'd0, bus.err},      32'h0);
        check("arst_cnt",   {28'd0, bus.err_cnt},  32'h0);
        check("arst_stall", {31'd0, bus.stall},    32'h0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        drive(2'b10, 1'b0, 1'b0);
        drive(2'b11, 1'b1, 1'b0);
        check("post_rst_err", {31'd0, bus.err},     32'h0);
        check("post_rst_cyc", {24'd0, bus.cyc_bcd}, 32'h0);

        // randomised traffic: mostly legal, occasional faults, holds and clears
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                nxt = pred(last_s, last_k);
                drive(nxt, ~nxt[0], 1'b0);
                repeat ($urandom_range(10, 25)) drive(nxt, ~nxt[0], 1'b0);
            end else if ($urandom_range(0, 99) < 85) begin
                drive(pred(last_s, last_k), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 19) == 0));
            end else begin
                drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 19) == 0));
            end
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/s_seq_monitor.md
Name: s_seq_monitor

Overview:
- Downstream checker for the 2-bit alternating-key sequence FSM (states 00→01→10→11→00).
- Samples the FSM state `s` and the key `k` that drives it, and predicts the next state.
- Counts completed sequence cycles as 2-digit BCD, flags illegal transitions, and detects a stalled sequence.
- Sits between the FSM and the display/LED stage. It is on the same `clk`/`clr` domain as the FSM.

Parameters:
- STALL_MAX, 16, number of consecutive unchanged samples of `s` that raises `stall` (legal range 2..255).

Ports:
- clk  input  1  system clock, rising edge; shared with the upstream FSM.
- clr  input  1  asynchronous, active-high reset; shared with the upstream FSM.
- s  input  2  current state of the upstream FSM.
- k  input  1  key input, the same signal that feeds the upstream FSM.
- err_clr  input  1  synchronous clear of `err` and `err_cnt`.
- cyc_bcd  output  8  completed-cycle count; [7:4] is tens, [3:0] is units, BCD 00..99.
- cyc_wrap  output  1  one-cycle pulse when `cyc_bcd` rolls 99→00.
- err  output  1  sticky flag: an illegal transition has been seen.
- err_cnt  output  4  number of illegal transitions, saturating at 15.
- stall  output  1  `s` has been unchanged for STALL_MAX or more samples.

Behaviour:
- Reset (clr=1, async): all outputs are 0.
  - Internal registers are also 0: prev_s, prev_k, primed, stall counter.
- All outputs are registered. Every rising edge with clr=0 samples `s` and `k`.
- Prediction function f(ps,pk):
  - pk=1: 01→10, 11→00, 00 hold, 10 hold.
  - pk=0: 00→01, 10→11, 01 hold, 11 hold.
- primed:
  - Goes to 1 on the first edge after clr deasserts.
  - While primed=0, no check, count or stall update is done; only prev_s and prev_k are loaded.
- Check on each edge with primed=1:
  - mismatch = (s != f(prev_s, prev_k)).
  - On mismatch: err←1 and err_cnt←min(err_cnt+1, 15).
  - prev_s←s and prev_k←k on every edge.
- err_clr=1 on an edge with no mismatch: err←0, err_cnt←0.
- err_clr=1 on the same edge as a mismatch: the mismatch wins, giving err=1 and err_cnt=1.
- Cycle count:
  - Triggered when prev_s=11, s=00 and there is no mismatch.
  - cyc_bcd increments in BCD: units 9→0 carries into tens; 99→00.
  - cyc_wrap=1 for exactly the edge where 99→00 happens; otherwise 0.
  - A mismatching 11→00 (prev_k=0) is not counted.
- Stall:
  - The run counter resets to 1 whenever s != prev_s.
  - Otherwise it increments, saturating at STALL_MAX.
  - stall=1 while the counter is at or above STALL_MAX; it drops on the edge where `s` changes.
  - Stall is independent of error checking: a legal hold still accumulates.
- Latency: every output reflects the `s`/`k` sample taken at the same edge. That is one clock after the FSM drove the corresponding state.
- Reset mid-operation: all state returns to 0 immediately and primed=0, so the first post-reset sample is never checked.

Test Plan:
- Reset, then k=0,1,0,1 for 4 clocks (s: 00→01→10→11→00).
  - Required: cyc_bcd=0x01, err=0, stall=0, cyc_wrap=0.
- Drive 100 legal full cycles.
  - Required: cyc_bcd reaches 0x09→0x10 at cycle 10 and 0x99 at cycle 99.
  - At cycle 100: cyc_bcd=0x00, with cyc_wrap high for exactly 1 clock.
- Force s from 00 to 10, skipping 01, with prev_k=0.
  - Required: err=1, err_cnt=1 on that edge; cyc_bcd unchanged.
  - Inject 16 more illegal transitions: err_cnt saturates at 15.
- err_clr pulse alone: err=0, err_cnt=0.
  - err_clr on the same edge as an injected mismatch: err=1, err_cnt=1.
- Hold k=1 with s=00 for 20 clocks (STALL_MAX=16).
  - Required: stall rises on the 16th unchanged sample, err stays 0.
  - Then k=0: stall falls on the edge where s=01 is sampled.
- Assert clr mid-sequence with s=10 and cyc_bcd=0x05.
  - Required: all outputs 0 immediately.
  - The first sample after release is not checked, even if s≠00.
